hazard_ctrl: RTL

- Parametrised successor to the pipeline's simple stall block. Sits beside the five stage registers in the pipelined RV32I core.
- Adds four functions the simple stall block lacks:
  - load-use and RAW hazard detection;
  - EX-stage forwarding selects;
  - branch-redirect flush, including discard of a stale in-flight fetch response;
  - saturating performance counters.
- Still produces the ifid/exwb back-pressure stalls for multi-cycle instruction and data memories.

---
 rtl/hazard_ctrl_pkg.sv | 22 ++
 rtl/hazard_ctrl_sat_counter.sv | 31 +++
 rtl/hazard_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard controller: forwarding selects
// and the memory-handshake FSM state encodings.
package rv32i_types;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IMEM_IDLE    = 2'd0,
        IMEM_WAIT    = 2'd1,
        IMEM_DISCARD = 2'd2
    } imem_state_t;

    typedef enum logic {
        DMEM_IDLE = 1'b0,
        DMEM_WAIT = 1'b1
    } dmem_state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW/load-use stalls, EX forwarding selects,
// redirect flushes with stale-fetch discard, memory back-pressure and counters.
//
// state         | meaning
// IMEM_IDLE     | no fetch outstanding
// IMEM_WAIT     | fetch outstanding, response will be used
// IMEM_DISCARD  | fetch outstanding but squashed by a redirect; drop its response
// DMEM_IDLE     | no data access outstanding
// DMEM_WAIT     | data access outstanding, back end held until response
module hazard_ctrl
    import rv32i_types::*;
#(
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1_s,
    input  logic [REG_W-1:0] id_rs2_s,
    input  logic             ex_valid,
    input  logic             ex_regf_we,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd_s,
    input  logic [REG_W-1:0] ex_rs1_s,
    input  logic [REG_W-1:0] ex_rs2_s,
    input  logic             mem_valid,
    input  logic             mem_regf_we,
    input  logic             mem_is_load,
    input  logic [REG_W-1:0] mem_rd_s,
    input  logic             wb_valid,
    input  logic             wb_regf_we,
    input  logic [REG_W-1:0] wb_rd_s,
    input  logic             ex_redirect,
    output logic             ifid_stall,
    output logic             exwb_stall,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             imem_discard,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] cnt_imem,
    output logic [CNT_W-1:0] cnt_dmem,
    output logic [CNT_W-1:0] cnt_hazard,
    output logic [CNT_W-1:0] cnt_flush
);

    imem_state_t imem_q, imem_d;
    dmem_state_t dmem_q, dmem_d;

    logic imem_stall;
    logic dmem_stall;
    logic flush;
    logic raw_haz;
    logic ex_hit, mem_hit, wb_hit;
    logic mem_ld_hit_ex;

    function automatic logic rd_hit(input logic             v,
                                    input logic             we,
                                    input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] rs);
        return v && we && (rd != '0) && (rd == rs);
    endfunction

    function automatic fwd_sel_t pick_fwd(input logic [REG_W-1:0] rs);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (rd_hit(mem_valid, mem_regf_we, mem_rd_s, rs) && !mem_is_load) begin
            sel = FWD_MEM;
        end else if (rd_hit(wb_valid, wb_regf_we, wb_rd_s, rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_q <= IMEM_IDLE;
            dmem_q <= DMEM_IDLE;
        end else begin
            imem_q <= imem_d;
            dmem_q <= dmem_d;
        end
    end

    always_comb begin
        dmem_d = dmem_q;
        case (dmem_q)
            DMEM_IDLE: if (dmem_req) dmem_d = DMEM_WAIT;
            DMEM_WAIT: if (dmem_resp) dmem_d = dmem_req ? DMEM_WAIT : DMEM_IDLE;
            default:   dmem_d = DMEM_IDLE;
        endcase
    end

    // A redirect landing together with the response needs no DISCARD; ifid_flush squashes it.
    always_comb begin
        imem_d       = imem_q;
        imem_discard = 1'b0;
        case (imem_q)
            IMEM_IDLE: begin
                if (imem_req) imem_d = IMEM_WAIT;
            end
            IMEM_WAIT: begin
                if (imem_resp) begin
                    imem_d = imem_req ? IMEM_WAIT : IMEM_IDLE;
                end else if (flush) begin
                    imem_d = IMEM_DISCARD;
                end
            end
            IMEM_DISCARD: begin
                if (imem_resp) begin
                    imem_discard = 1'b1;
                    imem_d       = imem_req ? IMEM_WAIT : IMEM_IDLE;
                end
            end
            default: imem_d = IMEM_IDLE;
        endcase
    end

    assign imem_stall = ((imem_q == IMEM_WAIT) && !imem_resp) || (imem_q == IMEM_DISCARD);
    assign dmem_stall = (dmem_q == DMEM_WAIT) && !dmem_resp;

    assign ex_hit  = rd_hit(ex_valid, ex_regf_we, ex_rd_s, id_rs1_s)
                   | rd_hit(ex_valid, ex_regf_we, ex_rd_s, id_rs2_s);
    assign mem_hit = rd_hit(mem_valid, mem_regf_we, mem_rd_s, id_rs1_s)
                   | rd_hit(mem_valid, mem_regf_we, mem_rd_s, id_rs2_s);
    assign wb_hit  = rd_hit(wb_valid, wb_regf_we, wb_rd_s, id_rs1_s)
                   | rd_hit(wb_valid, wb_regf_we, wb_rd_s, id_rs2_s);

    assign raw_haz = id_valid & (FWD_EN ? (ex_hit & ex_is_load) : (ex_hit | mem_hit | wb_hit));

    assign flush       = ex_redirect & ~dmem_stall;
    assign exwb_stall  = dmem_stall;
    assign ifid_stall  = dmem_stall | imem_stall | raw_haz;
    assign idex_bubble = raw_haz & ~dmem_stall & ~ex_redirect;
    assign ifid_flush  = flush;
    assign idex_flush  = flush;

    assign fwd_a_sel = FWD_EN ? pick_fwd(ex_rs1_s) : FWD_RF;
    assign fwd_b_sel = FWD_EN ? pick_fwd(ex_rs2_s) : FWD_RF;

    // The load-use bubble must keep a load in MEM from feeding a live EX source.
    assign mem_ld_hit_ex = mem_is_load
                         & (rd_hit(mem_valid, mem_regf_we, mem_rd_s, ex_rs1_s)
                          | rd_hit(mem_valid, mem_regf_we, mem_rd_s, ex_rs2_s));

    assert property (@(posedge clk) disable iff (rst)
                     !(FWD_EN && ex_valid && mem_ld_hit_ex));

    sat_counter #(.W(CNT_W)) u_cnt_imem (
        .clk (clk), .rst (rst), .inc (imem_stall), .cnt (cnt_imem)
    );
    sat_counter #(.W(CNT_W)) u_cnt_dmem (
        .clk (clk), .rst (rst), .inc (dmem_stall), .cnt (cnt_dmem)
    );
    sat_counter #(.W(CNT_W)) u_cnt_hazard (
        .clk (clk), .rst (rst), .inc (idex_bubble), .cnt (cnt_hazard)
    );
    sat_counter #(.W(CNT_W)) u_cnt_flush (
        .clk (clk), .rst (rst), .inc (ifid_flush), .cnt (cnt_flush)
    );

endmodule
